instruction_fetch: RTL and testbench

Fetch stage that reads instructions from instruction memory at the program-counter address over a req/ack handshake. It owns the fetch PC, issues one memory read per instruction and advances the PC by 4 on each response. Fetched words are held in a one-entry valid/ready output buffer for decode. Branch/jump redirects load a new PC and squash any in-flight or buffered instruction.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_pc.sv | 29 ++
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// PC stride, canonical NOP and the PC alignment helper.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Instructions are word aligned; low two address bits are always dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter register: loads next_pc_i when load_i is set, otherwise holds.
// The next-PC choice (redirect / +4 / hold) is made by the owner of this block.
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] next_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;

    // PC state; reset value is aligned so a misconfigured RESET_PC cannot
    // produce an unaligned fetch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= align_pc(RESET_PC);
        end else if (load_i) begin
            pc_q <= next_pc_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one req/ack memory read per
// instruction, and holds the returned word in a one-entry valid/ready buffer.
// Redirects reload the PC and squash both buffered and in-flight words; an
// in-flight read that cannot be cancelled is drained in DRAIN and discarded.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_load;
    logic [31:0] target;
    logic [31:0] addr_q;
    logic [31:0] launch_addr;
    logic        launch;
    logic        buf_load;
    logic        buf_clear;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    assign target = align_pc(redirect_pc_i);

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (pc_load),
        .next_pc_i (pc_next),
        .pc_o      (pc)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, PC select, request launch and buffer control.
    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_next     = pc;
        launch      = 1'b0;
        launch_addr = pc;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_load     = 1'b1;
                    pc_next     = target;
                    buf_clear   = 1'b1;
                    launch      = 1'b1;
                    launch_addr = target;
                    state_d     = REQ;
                end else if (!valid_q || instr_ready_i) begin
                    launch  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    // Ack in the same cycle drops the word; otherwise drain it.
                    pc_load   = 1'b1;
                    pc_next   = target;
                    buf_clear = 1'b1;
                    state_d   = imem_ack_i ? IDLE : DRAIN;
                end else if (imem_ack_i) begin
                    pc_load  = 1'b1;
                    pc_next  = pc + PC_STEP;
                    buf_load = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                // Last redirect wins; the outstanding word is thrown away.
                if (redirect_i) begin
                    pc_load   = 1'b1;
                    pc_next   = target;
                    buf_clear = 1'b1;
                end
                if (imem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request address is captured at launch and held until the ack.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q <= 32'd0;
        end else if (launch) begin
            addr_q <= launch_addr;
        end
    end

    // Output buffer: redirect clears, ack loads, consume empties.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else if (buf_clear) begin
            valid_q <= 1'b0;
        end else if (buf_load) begin
            valid_q    <= 1'b1;
            instr_q    <= imem_rdata_i;
            instr_pc_q <= addr_q;
        end else if (instr_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign imem_req_o    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_o          = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. dut0 uses the default reset PC,
// dut1 uses 32'h1000; both share stimulus and the memory responder, which
// is keyed off dut0's request.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, instr0, ipc0, pc0;
    logic [31:0] addr1, instr1, ipc1, pc1;

    int n_cmp = 0;
    int n_err = 0;
    int mem_delay = 0;
    int wait_cnt = 0;

    always #5 clk_i = ~clk_i;

    instruction_fetch dut0 (
        .clk_i(clk_i), .reset_i(reset_i),
        .imem_req_o(req0), .imem_addr_o(addr0),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(valid0), .instr_o(instr0), .instr_pc_o(ipc0),
        .instr_ready_i(instr_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc0)
    );

    instruction_fetch #(.RESET_PC(32'h0000_1000)) dut1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(valid1), .instr_o(instr1), .instr_pc_o(ipc1),
        .instr_ready_i(instr_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        reset_i    = 1'b1;
        redirect_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    // Memory responder: ack mem_delay cycles after req is first seen high.
    initial begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'd0;
        forever begin
            @(negedge clk_i);
            if (req0 && !imem_ack_i) begin
                if (wait_cnt == mem_delay) begin
                    imem_ack_i   = 1'b1;
                    imem_rdata_i = addr0 ^ K;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                if (!req0) wait_cnt = 0;
            end
        end
    end

    initial begin
        reset_i       = 1'b1;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        #1;
        // Reset state
        chk("rst req", req0, 0);
        chk("rst valid", valid0, 0);
        chk("rst instr", instr0, 0);
        chk("rst ipc", ipc0, 0);
        chk("rst pc", pc0, 0);
        chk("rst pc1", pc1, 32'h1000);
        @(negedge clk_i);
        reset_i = 1'b0;

        // 1: zero-wait streaming, one instruction every two cycles
        mem_delay = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1 req", req0, 1);
            chk("t1 addr", addr0, 4 * k);
            chk("t1 vld lo", valid0, 0);
            step();
            chk("t1 vld", valid0, 1);
            chk("t1 req lo", req0, 0);
            chk("t1 ipc", ipc0, 4 * k);
            chk("t1 instr", instr0, (4 * k) ^ K);
            chk("t1 pc", pc0, 4 * k + 4);
        end

        // 2: backpressure holds buffer and stops fetching
        instr_ready_i = 1'b0;
        apply_reset();
        step();
        chk("t2 req", req0, 1);
        step();
        chk("t2 vld", valid0, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2 hold req", req0, 0);
            chk("t2 hold vld", valid0, 1);
            chk("t2 hold ipc", ipc0, 0);
            chk("t2 hold instr", instr0, K);
        end
        instr_ready_i = 1'b1;
        step();
        chk("t2 rel req", req0, 1);
        chk("t2 rel addr", addr0, 4);

        // 3: ack delayed 3 cycles
        apply_reset();
        mem_delay = 3;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3 req", req0, 1);
            chk("t3 addr", addr0, 0);
            chk("t3 pc", pc0, 0);
            chk("t3 vld", valid0, 0);
        end
        step();
        chk("t3 done vld", valid0, 1);
        chk("t3 done pc", pc0, 4);
        chk("t3 done ipc", ipc0, 0);

        // 4: redirect with read outstanding -> drain, stale word dropped
        apply_reset();
        mem_delay = 2;
        step();
        chk("t4 req", req0, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        chk("t4 drain req", req0, 1);
        chk("t4 drain addr", addr0, 0);
        chk("t4 drain pc", pc0, 32'h100);
        chk("t4 drain vld", valid0, 0);
        step();
        chk("t4 drain2 req", req0, 1);
        chk("t4 drain2 vld", valid0, 0);
        step();
        chk("t4 idle req", req0, 0);
        chk("t4 idle vld", valid0, 0);
        step();
        chk("t4 new req", req0, 1);
        chk("t4 new addr", addr0, 32'h100);
        chk("t4 new vld", valid0, 0);

        // 5: redirect coincident with ack -> dropped; redirect clears a full buffer
        apply_reset();
        mem_delay = 0;
        step();
        chk("t5 req", req0, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        chk("t5 vld", valid0, 0);
        chk("t5 req lo", req0, 0);
        chk("t5 pc", pc0, 32'h200);
        step();
        chk("t5 new addr", addr0, 32'h200);
        chk("t5 new vld", valid0, 0);
        step();
        chk("t5 got vld", valid0, 1);
        chk("t5 got ipc", ipc0, 32'h200);
        chk("t5 got pc", pc0, 32'h204);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        step();
        redirect_i = 1'b0;
        chk("t5 clr vld", valid0, 0);
        chk("t5 clr addr", addr0, 32'h300);
        chk("t5 clr req", req0, 1);

        // 6: PC wraps modulo 2^32
        apply_reset();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        step();
        redirect_i = 1'b0;
        chk("t6 pc", pc0, 32'hFFFF_FFFC);
        step();
        chk("t6 addr", addr0, 32'hFFFF_FFFC);
        step();
        chk("t6 ipc", ipc0, 32'hFFFF_FFFC);
        chk("t6 wrap pc", pc0, 0);

        // 7: asynchronous reset mid-REQ
        apply_reset();
        mem_delay = 3;
        step();
        chk("t7 req", req0, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t7 async req", req0, 0);
        chk("t7 async vld", valid0, 0);
        chk("t7 async instr", instr0, 0);
        chk("t7 async ipc", ipc0, 0);
        chk("t7 async pc1", pc1, 32'h1000);
        chk("t7 async req1", req1, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        step();
        chk("t7 post req1", req1, 1);
        chk("t7 post addr1", addr1, 32'h1000);
        chk("t7 post addr0", addr0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
